flit_packet_receiver: RTL and testbench
=======================================

FLIT_PACKET_RECEIVER -- requirements
Module: flit_packet_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: assembled-packet buffer entries, power of two, minimum 2.
REQ-002 SHALL have parameter AXON_CNT_BIT_WIDTH, default 1: axon index width.
REQ-003 SHALL have parameters X_COORDINATE and Y_COORDINATE, default 0: local 8-bit node address.
REQ-004 Ports, in this order:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  flit strobe from the router local output.
- data_in  input  4  flit.
- full  output  1  backpressure to the router local port.
- start  input  1  timestep pulse, one cycle wide.
- evt_valid  output  1  decoded event available.
- evt_ready  input  1  consumer accepts the event.
- evt_axon  output  AXON_CNT_BIT_WIDTH  axon index of the head event.
- spike  output  1<<AXON_CNT_BIT_WIDTH  spike vector for the previous timestep.
- overflow_err  output  1  sticky flag: flit was dropped.
- addr_err  output  1  sticky flag: packet was misaddressed.

Function
REQ-005 Packet SHALL be 32 bits sent as 8 flits, most significant flit first (bits 31:28 first).
REQ-006 Packet fields SHALL be: dest X in bits 31:24, dest Y in bits 23:16, axon index in the low AXON_CNT_BIT_WIDTH bits.
REQ-007 Each cycle with write_en high and full low SHALL shift data_in into the assembly register and increment a 3-bit flit counter, which wraps 7->0.
REQ-008 When the 8th flit is accepted, the packet SHALL complete on that edge.
- If X and Y match: push to the FIFO.
- Otherwise: discard the packet and set addr_err.
REQ-009 full SHALL be registered, and high exactly when FIFO occupancy equals FIFO_DEPTH.
REQ-010 A flit with write_en high while full is high SHALL be dropped, leave the counter unchanged, and set overflow_err.
REQ-011 FIFO SHALL be show-ahead.
- A packet completing at edge N SHALL raise evt_valid in cycle N+1 when the FIFO was empty.
- evt_axon SHALL be the head packet's axon field.
REQ-012 A pop SHALL occur on a cycle where evt_valid and evt_ready are both high.
- evt_valid and evt_axon SHALL stay stable while evt_ready is low.
REQ-013 A push and a pop in the same cycle SHALL leave occupancy unchanged and SHALL NOT drop the pushed packet.
REQ-014 Occupancy SHALL count 0..FIFO_DEPTH, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-015 start SHALL NOT affect flit assembly or FIFO contents.

Reset
REQ-016 reset SHALL clear synchronously, overriding every other input:
- flit counter and assembly register;
- FIFO pointers and occupancy;
- full, evt_valid, evt_axon, spike, accumulator, overflow_err, addr_err.
REQ-017 A partial packet in progress at reset SHALL be discarded.
- The next accepted flit SHALL be treated as flit 1.

Configuration
REQ-018 Macro SPIKE_VECTOR_EN SHALL compile the spike vector feature in or out.
- Defined: each pop sets accumulator bit evt_axon.
- Defined, start high: spike <= accumulator, and the accumulator clears.
- Defined, pop coinciding with start: the popped bit lands in the cleared, next-timestep accumulator, not in spike.
- Undefined: no accumulator exists, and spike is constant 0.
- Event port behaviour SHALL be identical in both builds.

Verification
REQ-019 X_COORDINATE=0, Y_COORDINATE=0, AXON_CNT_BIT_WIDTH=1, evt_ready=1.
- Stimulus: flits 0,0,0,0,0,0,0,1 on consecutive cycles.
- Response: evt_valid high one cycle after flit 8, evt_axon=1, FIFO empties.
REQ-020 Stimulus: packet 0x01000000 (dest X=1).
- Response: no event, addr_err=1, flit counter back at 0.
REQ-021 Stimulus: evt_ready=0, FIFO_DEPTH=4, five back-to-back packets.
- Response: full rises after packet 4.
- Response: packet-5 flits dropped and overflow_err=1.
- Response: after evt_ready=1, exactly 4 events in order.
REQ-022 SPIKE_VECTOR_EN defined.
- Stimulus: events with axon 0 and axon 1, then start.
- Response: spike=2'b11 next cycle, accumulator 0.
- Stimulus: pop coinciding with start.
- Response: that bit absent from spike and present at the following start.
REQ-023 Stimulus: reset asserted after 3 flits, then a full 8-flit packet.
- Response: exactly one event, decoded from the post-reset flits.
REQ-024 SPIKE_VECTOR_EN undefined.
- Stimulus: same traffic as REQ-022.
- Response: spike stays 0 and the event sequence is identical.

Source files
------------

// File: rtl/flit_packet_receiver.sv
// flit_packet_receiver: assembles 8 four-bit flits into 32-bit packets, filters them by node address and queues axon events.
// Ports: clk/reset (sync, active-high); write_en/data_in flit input with registered full backpressure;
// evt_valid/evt_ready/evt_axon show-ahead event output; start timestep pulse; spike previous-timestep vector;
// overflow_err/addr_err sticky error flags. Optional macro SPIKE_VECTOR_EN builds the spike accumulator.
module flit_packet_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int AXON_CNT_BIT_WIDTH = 1,
  parameter logic [7:0] X_COORDINATE = 8'd0,
  parameter logic [7:0] Y_COORDINATE = 8'd0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 write_en,
  input  logic [3:0]                           data_in,
  output logic                                 full,
  input  logic                                 start,
  output logic                                 evt_valid,
  input  logic                                 evt_ready,
  output logic [AXON_CNT_BIT_WIDTH-1:0]        evt_axon,
  output logic [(1<<AXON_CNT_BIT_WIDTH)-1:0]   spike,
  output logic                                 overflow_err,
  output logic                                 addr_err
);
  localparam int AW = AXON_CNT_BIT_WIDTH;
  localparam int NS = 1 << AW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  logic [2:0] cnt_q, cnt_d;
  logic [27:0] asm_q, asm_d;
  logic [AW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] occ_q, occ_d;
  logic full_q, full_d, ovf_q, ovf_d, aerr_q, aerr_d;
  logic accept, last, hit, push, pop;
  logic [AW-1:0] axon;
  assign evt_valid = occ_q != '0;
  assign evt_axon = evt_valid ? mem_q[rd_q] : '0;
  assign full = full_q;
  assign overflow_err = ovf_q;
  assign addr_err = aerr_q;
  // Seven flits already sit in asm_q when the eighth arrives, so the address
  // fields are read from asm_q and the axon from the completed packet's low bits.
  always_comb begin
    accept = write_en & ~full_q;
    last = accept & (cnt_q == 3'd7);
    hit = (asm_q[27:20] == X_COORDINATE) && (asm_q[19:12] == Y_COORDINATE);
    push = last & hit;
    pop = evt_valid & evt_ready;
    axon = AW'({asm_q, data_in});
    cnt_d = accept ? cnt_q + 3'd1 : cnt_q;
    asm_d = accept ? {asm_q[23:0], data_in} : asm_q;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = axon;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    occ_d = (push & ~pop) ? occ_q + (PW+1)'(1) : (pop & ~push) ? occ_q - (PW+1)'(1) : occ_q;
    full_d = occ_d == DEPTH;
    ovf_d = ovf_q | (write_en & full_q);
    aerr_d = aerr_q | (last & ~hit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      asm_q <= '0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      aerr_q <= aerr_d;
    end
  end
`ifdef SPIKE_VECTOR_EN
  logic [NS-1:0] acc_q, acc_d, spike_q, spike_d, pop_bit;
  // A pop on the start edge belongs to the new timestep, so it lands in the cleared accumulator.
  always_comb begin
    pop_bit = pop ? NS'(1) << evt_axon : '0;
    spike_d = start ? acc_q : spike_q;
    acc_d = (start ? '0 : acc_q) | pop_bit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      spike_q <= '0;
    end else begin
      acc_q <= acc_d;
      spike_q <= spike_d;
    end
  end
  assign spike = spike_q;
`else
  logic unused_start;
  assign unused_start = start;
  assign spike = '0;
`endif
endmodule

// File: tb/tb_flit_packet_receiver.sv
// tb_flit_packet_receiver: directed traffic against a queue-based model of the packet receiver.
module tb_flit_packet_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write_en = 1'b0;
  logic start = 1'b0;
  logic evt_ready = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic full, evt_valid, overflow_err, addr_err;
  logic [0:0] evt_axon;
  logic [1:0] spike;
  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  int q[$];
  int m_nfl = 0;
  logic [31:0] m_pkt = '0;
  bit m_ovf = 1'b0;
  bit m_aerr = 1'b0;
  logic [1:0] m_acc = '0;
  logic [1:0] m_spike = '0;
  flit_packet_receiver dut (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .full(full),
    .start(start), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_axon(evt_axon),
    .spike(spike), .overflow_err(overflow_err), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic model();
    bit f, v;
    int head;
    f = q.size() == 4;
    v = q.size() != 0;
    head = v ? q[0] : 0;
    if (reset) begin
      q.delete();
      m_nfl = 0;
      m_pkt = '0;
      m_ovf = 1'b0;
      m_aerr = 1'b0;
      m_acc = '0;
      m_spike = '0;
      return;
    end
    if (write_en && f) m_ovf = 1'b1;
    if (v && evt_ready) void'(q.pop_front());
`ifdef SPIKE_VECTOR_EN
    if (start) begin
      m_spike = m_acc;
      m_acc = '0;
    end
    if (v && evt_ready) m_acc[head] = 1'b1;
`endif
    if (write_en && !f) begin
      m_pkt = {m_pkt[27:0], data_in};
      m_nfl++;
      if (m_nfl == 8) begin
        m_nfl = 0;
        if (m_pkt[31:16] == 16'h0000) q.push_back(int'(m_pkt[0]));
        else m_aerr = 1'b1;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
  endtask
  task automatic send(input logic [31:0] p);
    for (int i = 7; i >= 0; i--) begin
      write_en = 1'b1;
      data_in = p[4*i +: 4];
      tick();
    end
    write_en = 1'b0;
  endtask
  always @(negedge clk) if (chk_en) begin
    check("evt_valid", evt_valid, q.size() != 0);
    if (q.size() != 0) check("evt_axon", evt_axon, q[0]);
    check("full", full, q.size() == 4);
    check("overflow_err", overflow_err, m_ovf);
    check("addr_err", addr_err, m_aerr);
    check("spike", spike, m_spike);
  end
  initial begin
    int exp_order[4] = '{1, 0, 1, 1};
    int got[$];
    int n;
    logic [1:0] sp_exp;
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_axon", evt_axon, 0);
    check("rst_full", full, 0);
    check("rst_spike", spike, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_addr_err", addr_err, 0);
    evt_ready = 1'b1;
    send(32'h0000_0001);
    check("pkt1_valid", evt_valid, 1);
    check("pkt1_axon", evt_axon, 1);
    tick();
    check("pkt1_drained", evt_valid, 0);
    send(32'h0100_0000);
    check("misaddr_err", addr_err, 1);
    check("misaddr_noevt", evt_valid, 0);
    send(32'h0000_0000);
    check("after_misaddr_valid", evt_valid, 1);
    check("after_misaddr_axon", evt_axon, 0);
    tick();
    evt_ready = 1'b0;
    send(32'h0000_0001);
    send(32'h0000_0000);
    send(32'h0000_0001);
    send(32'h0000_0001);
    check("full_after4", full, 1);
    check("no_ovf_yet", overflow_err, 0);
    send(32'h0000_0000);
    check("ovf_after5", overflow_err, 1);
    check("still_full", full, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (evt_valid) got.push_back(int'(evt_axon));
      tick();
    end
    check("drain_count", got.size(), 4);
    for (int k = 0; k < 4; k++) check("drain_order", k < got.size() ? got[k] : 99, exp_order[k]);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("spike_flushed", spike, 0);
    send(32'h0000_0000);
    send(32'h0000_0001);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SPIKE_VECTOR_EN
    sp_exp = 2'b11;
`else
    sp_exp = 2'b00;
`endif
    check("spike_both", spike, sp_exp);
    evt_ready = 1'b0;
    send(32'h0000_0000);
    tick();
    check("held_valid", evt_valid, 1);
    check("held_axon", evt_axon, 0);
    evt_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("coincide_spike", spike, 0);
    check("coincide_popped", evt_valid, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SPIKE_VECTOR_EN
    sp_exp = 2'b01;
`else
    sp_exp = 2'b00;
`endif
    check("carried_spike", spike, sp_exp);
    write_en = 1'b1;
    data_in = 4'hF;
    tick();
    tick();
    tick();
    write_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_addr_err", addr_err, 0);
    check("midrst_ovf", overflow_err, 0);
    check("midrst_spike", spike, 0);
    n = 0;
    send(32'h0000_0001);
    check("midrst_axon", evt_axon, 1);
    for (int i = 0; i < 4; i++) begin
      if (evt_valid) n++;
      tick();
    end
    check("midrst_events", n, 1);
    check("midrst_no_addr_err", addr_err, 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
